// File: rtl/lut_sweep_pkg.sv
// lut_sweep_pkg: shared sweep state enumeration and the N=3 reset truth table
package lut_sweep_pkg;
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;
    localparam logic [7:0] DEFAULT_LUT_N3 = 8'h70;
endpackage

// File: rtl/lut_eval.sv
// lut_eval: combinational 2^N:1 bit mux selecting lut_i[idx_i]
//   lut_i : truth table, bit i = f(i)
//   idx_i : index, bit N-1 is the MSB
//   bit_o : selected table bit
module lut_eval #(
    parameter int N = 3
) (
    input  logic [2**N-1:0] lut_i,
    input  logic [N-1:0]    idx_i,
    output logic            bit_o
);
    assign bit_o = lut_i[idx_i];
endmodule

// File: rtl/lut_sweep.sv
// lut_sweep: programmable N-input LUT with direct evaluation and a self-test sweep
//   cfg_we/cfg_lut : truth-table load, honoured only in IDLE
//   x_in/y         : registered direct evaluation, 1-cycle latency
//   start/expected : sweep request and golden table, sampled at start
//   busy/done      : sweep in progress / one-cycle completion pulse
//   result, mismatch, first_err_idx, err_count : sweep outcome, held until next start
module lut_sweep
    import lut_sweep_pkg::*;
#(
    parameter int             N           = 3,
    parameter logic [2**N-1:0] DEFAULT_LUT = DEFAULT_LUT_N3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [2**N-1:0] cfg_lut,
    input  logic [N-1:0]    x_in,
    output logic            y,
    input  logic            start,
    input  logic [2**N-1:0] expected,
    output logic            busy,
    output logic            done,
    output logic [2**N-1:0] result,
    output logic            mismatch,
    output logic [N-1:0]    first_err_idx,
    output logic [N:0]      err_count
);
    localparam logic [N-1:0] LAST = '1;
    state_e          state_q;
    logic [2**N-1:0] lut_q, exp_q, result_q;
    logic [N-1:0]    idx_q, first_q;
    logic [N:0]      err_q;
    logic            y_q, busy_q, done_q, mismatch_q;
    logic            x_bit, idx_bit;
    lut_eval #(.N(N)) u_eval_x   (.lut_i(lut_q), .idx_i(x_in),  .bit_o(x_bit));
    lut_eval #(.N(N)) u_eval_idx (.lut_i(lut_q), .idx_i(idx_q), .bit_o(idx_bit));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lut_q      <= DEFAULT_LUT;
            exp_q      <= '0;
            result_q   <= '0;
            idx_q      <= '0;
            first_q    <= '0;
            err_q      <= '0;
            y_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            y_q <= x_bit;
            case (state_q)
                IDLE: begin
                    // a same-edge load is seen by the sweep, which reads lut_q from the next edge on
                    if (cfg_we) lut_q <= cfg_lut;
                    if (start) begin
                        state_q    <= SWEEP;
                        busy_q     <= 1'b1;
                        exp_q      <= expected;
                        result_q   <= '0;
                        mismatch_q <= 1'b0;
                        first_q    <= '0;
                        err_q      <= '0;
                        idx_q      <= '0;
                    end
                end
                SWEEP: begin
                    result_q[idx_q] <= idx_bit;
                    if (idx_bit != exp_q[idx_q]) begin
                        err_q      <= err_q + (N+1)'(1);
                        mismatch_q <= 1'b1;
                        if (!mismatch_q) first_q <= idx_q;
                    end
                    // idx stops at the last entry rather than wrapping
                    if (idx_q == LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + N'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
    assign y             = y_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign result        = result_q;
    assign mismatch      = mismatch_q;
    assign first_err_idx = first_q;
    assign err_count     = err_q;
endmodule

// File: doc/lut_sweep.md
LUT_SWEEP -- requirements
Module: lut_sweep

Interface
REQ-001 SHALL have parameter N, default 3, meaning number of boolean inputs (legal range 1..6).
REQ-002 SHALL have parameter DEFAULT_LUT, default 8'h70 (width 2^N), meaning truth table loaded at reset; bit i = f(i), and input bit N-1 is the MSB of the index.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cfg_we, input, 1, truth-table write enable.
REQ-006 SHALL have port cfg_lut, input, 2^N, new truth table.
REQ-007 SHALL have port x_in, input, N, direct-evaluation operand.
REQ-008 SHALL have port y, output, 1, registered f(x_in).
REQ-009 SHALL have port start, input, 1, sweep request.
REQ-010 SHALL have port expected, input, 2^N, golden truth table for the sweep.
REQ-011 SHALL have port busy, output, 1, high while in SWEEP or DONE.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port result, output, 2^N, captured truth table.
REQ-014 SHALL have port mismatch, output, 1, at least one result bit differs from expected.
REQ-015 SHALL have port first_err_idx, output, N, lowest differing index, 0 if none.
REQ-016 SHALL have port err_count, output, N+1, number of differing indices.

Function
REQ-017 SHALL hold the truth table in an internal 2^N-bit register lut.
REQ-018 SHALL load cfg_lut into lut on an edge with cfg_we=1 only in IDLE; cfg_we is ignored in SWEEP and DONE.
REQ-019 SHALL register y = lut[x_in] every cycle, in every state; latency is 1 cycle.
REQ-020 SHALL implement states IDLE, SWEEP and DONE.
REQ-021 SHALL move IDLE->SWEEP on an edge with start=1, and at that edge:
- capture expected into an internal copy;
- clear result, mismatch, first_err_idx, err_count;
- set index idx=0.
REQ-022 SHALL, on each SWEEP edge:
- write result[idx] = lut[idx];
- when lut[idx] != expected copy[idx], increment err_count and set mismatch;
- on the first such difference only, load first_err_idx = idx;
- increment idx.
REQ-023 SHALL move SWEEP->DONE on the edge that processes idx = 2^N-1; idx does not wrap.
REQ-024 SHALL assert done for exactly the one DONE cycle, then move DONE->IDLE unconditionally.
REQ-025 SHALL give cycle-level timing: start sampled at edge t; SWEEP occupies 2^N cycles; done is high in the cycle after edge t+2^N.
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL handle start and cfg_we at the same IDLE edge as follows: lut takes cfg_lut, and the sweep evaluates the new table.
REQ-028 SHALL hold result, mismatch, first_err_idx and err_count stable from DONE until the next accepted start.
REQ-029 SHALL sample expected only at start; later changes to expected have no effect on the running sweep.

Reset
REQ-030 SHALL, on rst_n=0, immediately and regardless of state, set:
- state=IDLE, lut=DEFAULT_LUT, idx=0, y=0;
- busy=0, done=0, result=0;
- mismatch=0, first_err_idx=0, err_count=0.
REQ-031 SHALL abort a sweep in progress when reset is asserted mid-sweep, with no done pulse after release.

Structure
REQ-032 SHALL place the state enumeration and the DEFAULT_LUT constant for N=3 (8'h70) in shared package lut_sweep_pkg.
REQ-033 SHALL implement evaluation (2^N:1 bit mux of lut by index) in one combinational sub-module lut_eval, instantiated twice: once for x_in and once for idx.

Verification
REQ-034 SHALL cover, with N=3: after reset, start=1 with expected=8'h70 -> done exactly once, 9 cycles after the start edge; result=8'h70, mismatch=0, err_count=0.
REQ-035 SHALL cover: expected=8'h78 with default table -> result=8'h70, mismatch=1, first_err_idx=3, err_count=1.
REQ-036 SHALL cover direct evaluation: x_in=3'b101 -> y=1 one cycle later; x_in=3'b111 -> y=0.
REQ-037 SHALL cover: cfg_we=1 with cfg_lut=8'hFF during SWEEP is ignored; cfg_lut=8'hFF written in IDLE, then sweep with expected=8'h70 -> mismatch=1, first_err_idx=0, err_count=5.
REQ-038 SHALL cover: rst_n pulsed low at SWEEP idx=4 -> all outputs 0, busy=0, no done; the next sweep completes normally.
REQ-039 SHALL cover a second build with N=1, DEFAULT_LUT=2'b10 and expected=2'b10 -> done 3 cycles after start, err_count=0.
